// File: rtl/alarm_controller.sv
// Alarm setpoint, HH:MM:00 match detection and ring/snooze/timeout sequencing.
// Define ALARM_BEEP_EN for an intermittent buzzer that toggles on each tick; otherwise the tone is steady.
module alarm_controller #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [5:0] secCount,
    input  logic [5:0] minCount,
    input  logic [4:0] hourCount,
    input  logic       updown,
    input  logic       set_min,
    input  logic       set_hour,
    input  logic       armed,
    input  logic       snooze,
    input  logic       stop,
    output logic [5:0] alarmMin,
    output logic [4:0] alarmHour,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzz
);

    localparam int RW = $clog2(RING_TIMEOUT + 1);
    localparam int SW = $clog2(SNOOZE_TICKS + 1);
    localparam int CW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [RW-1:0] ring_cnt, ring_cnt_next;
    logic [SW-1:0] snz_cnt, snz_cnt_next;
    logic [CW-1:0] snz_num, snz_num_next;
    logic          match, match_q, adj_q, trigger;

    assign match   = (hourCount == alarmHour) && (minCount == alarmMin) && (secCount == 6'd0);
    // adj_q blocks a match that was created by editing the setpoint rather than by time advancing.
    assign trigger = armed && match && !match_q && !adj_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarmMin  <= 6'd0;
            alarmHour <= 5'd0;
            match_q   <= 1'b0;
            adj_q     <= 1'b0;
        end else begin
            match_q <= match;
            adj_q   <= set_min | set_hour;
            if (set_min) begin
                if (updown)
                    alarmMin <= (alarmMin == 6'd59) ? 6'd0 : alarmMin + 6'd1;
                else
                    alarmMin <= (alarmMin == 6'd0) ? 6'd59 : alarmMin - 6'd1;
            end
            if (set_hour) begin
                if (updown)
                    alarmHour <= (alarmHour == 5'd23) ? 5'd0 : alarmHour + 5'd1;
                else
                    alarmHour <= (alarmHour == 5'd0) ? 5'd23 : alarmHour - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_num  <= '0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            state    <= state_next;
            ring_cnt <= ring_cnt_next;
            snz_cnt  <= snz_cnt_next;
            snz_num  <= snz_num_next;
            ringing  <= (state_next == RINGING);
            snoozing <= (state_next == SNOOZE);
        end
    end

    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;
        snz_num_next  = snz_num;
        if (!armed) begin
            state_next    = IDLE;
            ring_cnt_next = '0;
            snz_cnt_next  = '0;
            snz_num_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state_next    = RINGING;
                        ring_cnt_next = RW'(RING_TIMEOUT);
                        snz_num_next  = '0;
                    end
                end
                RINGING: begin
                    // A snooze arriving with the final tick wins over the timeout.
                    if (stop) begin
                        state_next   = IDLE;
                        snz_num_next = '0;
                    end else if (snooze && (snz_num < CW'(MAX_SNOOZE))) begin
                        state_next   = SNOOZE;
                        snz_cnt_next = SW'(SNOOZE_TICKS);
                        snz_num_next = snz_num + CW'(1);
                    end else if (tick) begin
                        if (ring_cnt == RW'(1))
                            state_next = IDLE;
                        else
                            ring_cnt_next = ring_cnt - RW'(1);
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_next   = IDLE;
                        snz_num_next = '0;
                    end else if (tick) begin
                        if (snz_cnt == SW'(1)) begin
                            state_next    = RINGING;
                            ring_cnt_next = RW'(RING_TIMEOUT);
                        end else begin
                            snz_cnt_next = snz_cnt - SW'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef ALARM_BEEP_EN
    // Beep starts high on every entry to RINGING (including re-ring after snooze).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            buzz <= 1'b0;
        else if (state_next != RINGING)
            buzz <= 1'b0;
        else if (state != RINGING)
            buzz <= 1'b1;
        else if (tick)
            buzz <= ~buzz;
    end
`else
    assign buzz = ringing;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller (RING_TIMEOUT=4, SNOOZE_TICKS=3, MAX_SNOOZE=2).
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst, tick, updown, set_min, set_hour, armed, snooze, stop;
    logic [5:0] sec_count, min_count;
    logic [4:0] hour_count;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       ringing, snoozing, buzz;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alarm_controller #(.RING_TIMEOUT(4), .SNOOZE_TICKS(3), .MAX_SNOOZE(2)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .secCount(sec_count), .minCount(min_count), .hourCount(hour_count),
        .updown(updown), .set_min(set_min), .set_hour(set_hour),
        .armed(armed), .snooze(snooze), .stop(stop),
        .alarmMin(alarm_min), .alarmHour(alarm_hour),
        .ringing(ringing), .snoozing(snoozing), .buzz(buzz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_tick();
        tick = 1'b1; step(); tick = 1'b0; step();
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1; step(); snooze = 1'b0;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hour_count = h; min_count = m; sec_count = s;
    endtask

    // Moves time off the alarm and back onto 07:30:00 so a fresh trigger occurs.
    task automatic fire_alarm();
        set_time(5'd7, 6'd29, 6'd59); step_n(2);
        set_time(5'd7, 6'd30, 6'd0);  step();
    endtask

    task automatic test_reset();
        rst = 1'b0; tick = 0; updown = 1; set_min = 0; set_hour = 0;
        armed = 0; snooze = 0; stop = 0;
        set_time(5'd0, 6'd0, 6'd0);
        #12;
        checks++; if (ringing !== 1'b0) begin errors++; $display("[TB] FAIL reset_ringing got=%b exp=0", ringing); end
        checks++; if (snoozing !== 1'b0) begin errors++; $display("[TB] FAIL reset_snoozing got=%b exp=0", snoozing); end
        checks++; if (buzz !== 1'b0) begin errors++; $display("[TB] FAIL reset_buzz got=%b exp=0", buzz); end
        checks++; if (alarm_min !== 6'd0) begin errors++; $display("[TB] FAIL reset_min got=%0d exp=0", alarm_min); end
        checks++; if (alarm_hour !== 5'd0) begin errors++; $display("[TB] FAIL reset_hour got=%0d exp=0", alarm_hour); end
        step(); rst = 1'b1; step();
    endtask

    task automatic test_setpoint_wrap();
        updown = 1'b1;
        for (int i = 0; i < 60; i++) begin
            set_min = 1'b1; step(); set_min = 1'b0;
            if (i == 58) begin
                checks++; if (alarm_min !== 6'd59) begin errors++; $display("[TB] FAIL wrap_min59 got=%0d exp=59", alarm_min); end
            end
        end
        checks++; if (alarm_min !== 6'd0) begin errors++; $display("[TB] FAIL wrap_min0 got=%0d exp=0", alarm_min); end
        updown = 1'b0; set_hour = 1'b1; step(); set_hour = 1'b0;
        checks++; if (alarm_hour !== 5'd23) begin errors++; $display("[TB] FAIL wrap_hour23 got=%0d exp=23", alarm_hour); end
        updown = 1'b1; set_hour = 1'b1; step(); set_hour = 1'b0;
        checks++; if (alarm_hour !== 5'd0) begin errors++; $display("[TB] FAIL wrap_hour0 got=%0d exp=0", alarm_hour); end
        for (int i = 0; i < 30; i++) begin
            set_min = 1'b1; set_hour = (i < 7); step();
        end
        set_min = 1'b0; set_hour = 1'b0;
        checks++; if (alarm_min !== 6'd30 || alarm_hour !== 5'd7) begin errors++; $display("[TB] FAIL set_0730 got=%0d:%0d exp=7:30", alarm_hour, alarm_min); end
    endtask

    task automatic test_basic_alarm();
        armed = 1'b1;
        set_time(5'd7, 6'd29, 6'd59); step_n(3);
        checks++; if (ringing !== 1'b0) begin errors++; $display("[TB] FAIL basic_pre got=%b exp=0", ringing); end
        set_time(5'd7, 6'd30, 6'd0);
        checks++; if (ringing !== 1'b0) begin errors++; $display("[TB] FAIL basic_before_edge got=%b exp=0", ringing); end
        step();
        checks++; if (ringing !== 1'b1 || snoozing !== 1'b0) begin errors++; $display("[TB] FAIL basic_ring got=%b%b exp=10", ringing, snoozing); end
        for (int i = 0; i < 3; i++) pulse_tick();
        checks++; if (ringing !== 1'b1) begin errors++; $display("[TB] FAIL basic_tick3 got=%b exp=1", ringing); end
        pulse_tick();
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout got=%b%b exp=00", ringing, snoozing); end
        step_n(3);
        checks++; if (ringing !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_refire got=%b exp=0", ringing); end
    endtask

    task automatic test_snooze_limit();
        fire_alarm();
        checks++; if (ringing !== 1'b1) begin errors++; $display("[TB] FAIL snz_fire got=%b exp=1", ringing); end
        pulse_snooze();
        checks++; if (snoozing !== 1'b1 || ringing !== 1'b0) begin errors++; $display("[TB] FAIL snz_first got=%b%b exp=01", ringing, snoozing); end
        pulse_tick(); pulse_tick();
        checks++; if (snoozing !== 1'b1) begin errors++; $display("[TB] FAIL snz_tick2 got=%b exp=1", snoozing); end
        pulse_tick();
        checks++; if (ringing !== 1'b1 || snoozing !== 1'b0) begin errors++; $display("[TB] FAIL snz_rering1 got=%b%b exp=10", ringing, snoozing); end
        pulse_snooze();
        checks++; if (snoozing !== 1'b1) begin errors++; $display("[TB] FAIL snz_second got=%b exp=1", snoozing); end
        for (int i = 0; i < 3; i++) pulse_tick();
        checks++; if (ringing !== 1'b1) begin errors++; $display("[TB] FAIL snz_rering2 got=%b exp=1", ringing); end
        pulse_snooze();
        checks++; if (ringing !== 1'b1 || snoozing !== 1'b0) begin errors++; $display("[TB] FAIL snz_third_ignored got=%b%b exp=10", ringing, snoozing); end
        for (int i = 0; i < 3; i++) pulse_tick();
        checks++; if (ringing !== 1'b1) begin errors++; $display("[TB] FAIL snz_final_tick3 got=%b exp=1", ringing); end
        pulse_tick();
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("[TB] FAIL snz_final_timeout got=%b%b exp=00", ringing, snoozing); end
    endtask

    task automatic test_priority();
        fire_alarm();
        stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("[TB] FAIL prio_stop got=%b%b exp=00", ringing, snoozing); end
        for (int i = 0; i < 3; i++) pulse_tick();
        checks++; if (ringing !== 1'b0) begin errors++; $display("[TB] FAIL prio_stop_stays got=%b exp=0", ringing); end
        fire_alarm();
        pulse_snooze();
        checks++; if (snoozing !== 1'b1) begin errors++; $display("[TB] FAIL prio_snz got=%b exp=1", snoozing); end
        armed = 1'b0; step();
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("[TB] FAIL prio_disarm got=%b%b exp=00", ringing, snoozing); end
        armed = 1'b1;
        for (int i = 0; i < 4; i++) pulse_tick();
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("[TB] FAIL prio_no_rering got=%b%b exp=00", ringing, snoozing); end
        fire_alarm();
        for (int i = 0; i < 3; i++) pulse_tick();
        tick = 1'b1; snooze = 1'b1; step(); tick = 1'b0; snooze = 1'b0;
        checks++; if (snoozing !== 1'b1 || ringing !== 1'b0) begin errors++; $display("[TB] FAIL prio_snz_at_expiry got=%b%b exp=01", ringing, snoozing); end
        stop = 1'b1; step(); stop = 1'b0;
        checks++; if (snoozing !== 1'b0) begin errors++; $display("[TB] FAIL prio_stop_snz got=%b exp=0", snoozing); end
    endtask

    task automatic test_no_false_trigger();
        set_time(5'd7, 6'd30, 6'd0); step_n(2);
        updown = 1'b0; set_min = 1'b1; step(); set_min = 1'b0;
        checks++; if (alarm_min !== 6'd29) begin errors++; $display("[TB] FAIL edit_down got=%0d exp=29", alarm_min); end
        step_n(2);
        updown = 1'b1; set_min = 1'b1; step(); set_min = 1'b0;
        checks++; if (alarm_min !== 6'd30) begin errors++; $display("[TB] FAIL edit_up got=%0d exp=30", alarm_min); end
        step_n(3);
        checks++; if (ringing !== 1'b0) begin errors++; $display("[TB] FAIL edit_no_trigger got=%b exp=0", ringing); end
    endtask

    task automatic test_countdown();
        set_time(5'd7, 6'd30, 6'd1); step_n(2);
        set_time(5'd7, 6'd30, 6'd0); tick = 1'b1; step(); tick = 1'b0;
        checks++; if (ringing !== 1'b1) begin errors++; $display("[TB] FAIL down_ring got=%b exp=1", ringing); end
        for (int i = 0; i < 3; i++) pulse_tick();
        checks++; if (ringing !== 1'b1) begin errors++; $display("[TB] FAIL down_entry_tick_ignored got=%b exp=1", ringing); end
        pulse_tick();
        checks++; if (ringing !== 1'b0) begin errors++; $display("[TB] FAIL down_timeout got=%b exp=0", ringing); end
    endtask

    task automatic test_beep();
        logic [3:0] exp_buzz;
`ifdef ALARM_BEEP_EN
        exp_buzz = 4'b0101;
`else
        exp_buzz = 4'b1111;
`endif
        fire_alarm();
        for (int i = 0; i < 4; i++) begin
            checks++; if (buzz !== exp_buzz[i]) begin errors++; $display("[TB] FAIL beep_%0d got=%b exp=%b", i, buzz, exp_buzz[i]); end
            pulse_tick();
        end
        checks++; if (buzz !== 1'b0) begin errors++; $display("[TB] FAIL beep_off got=%b exp=0", buzz); end
    endtask

    task automatic test_async_reset();
        fire_alarm();
        pulse_snooze();
        for (int i = 0; i < 3; i++) pulse_tick();
        checks++; if (ringing !== 1'b1 || buzz !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre got=%b%b exp=11", ringing, buzz); end
        #2 rst = 1'b0;
        #1;
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0 || buzz !== 1'b0) begin errors++; $display("[TB] FAIL areset_out got=%b%b%b exp=000", ringing, snoozing, buzz); end
        checks++; if (alarm_min !== 6'd0 || alarm_hour !== 5'd0) begin errors++; $display("[TB] FAIL areset_set got=%0d:%0d exp=0:0", alarm_hour, alarm_min); end
        set_time(5'd0, 6'd0, 6'd0);
        step();
        rst = 1'b1;
        checks++; if (ringing !== 1'b0) begin errors++; $display("[TB] FAIL areset_release got=%b exp=0", ringing); end
        step();
        checks++; if (ringing !== 1'b1) begin errors++; $display("[TB] FAIL areset_refire got=%b exp=1", ringing); end
        armed = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_setpoint_wrap();
        test_basic_alarm();
        test_snooze_limit();
        test_priority();
        test_no_false_trigger();
        test_countdown();
        test_beep();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Downstream consumer of the clock block's time counts. Holds a user-adjustable alarm setpoint (hour/minute) and detects when the running time reaches HH:MM:00. Sequences the alarm through ringing, snooze and auto-timeout, and drives the buzzer and status outputs for the display/IO stage.

## Interface
- RING_TIMEOUT, 60: ticks the alarm rings before auto-stop (≥1)
- SNOOZE_TICKS, 300: ticks spent in snooze before re-ringing (≥1)
- MAX_SNOOZE, 3: snoozes allowed per alarm event (≥0)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  1 Hz single-cycle pulse (same enable that advances the seconds counter)
- secCount  in  6  current seconds, 0..59
- minCount  in  6  current minutes, 0..59
- hourCount  in  5  current hours, 0..23
- updown  in  1  setpoint adjust direction: 1 = increment, 0 = decrement
- set_min  in  1  single-cycle pulse: step alarm minute
- set_hour  in  1  single-cycle pulse: step alarm hour
- armed  in  1  level: alarm enabled
- snooze  in  1  single-cycle pulse: request snooze
- stop  in  1  single-cycle pulse: dismiss alarm
- alarmMin  out  6  alarm minute setpoint
- alarmHour  out  5  alarm hour setpoint
- ringing  out  1  high in RINGING
- snoozing  out  1  high in SNOOZE
- buzz  out  1  buzzer drive

## Operation
- Reset: alarmMin=0, alarmHour=0, ringing=0, snoozing=0, buzz=0, state IDLE, snooze count 0, match_q=0.
- Setpoint: set_min steps alarmMin by ±1, with wrap 59→0 / 0→59. set_hour does the same for alarmHour, with wrap 23→0 / 0→23. Adjustment is allowed in every state. set_min and set_hour together both apply.
- match = (hourCount==alarmHour) & (minCount==alarmMin) & (secCount==0). match_q is match registered every cycle.
- trigger = armed & match & !match_q & !adj_q, where adj_q is a register of (set_min|set_hour). A setpoint edit that creates a match never fires the alarm. Trigger works with time counting in either direction.
- States:
  - IDLE: trigger → RINGING; load ring counter = RING_TIMEOUT; snooze count = 0.
  - RINGING: on tick, decrement ring counter; tick with counter==1 → IDLE. snooze with snooze count < MAX_SNOOZE → SNOOZE; load snooze counter = SNOOZE_TICKS; snooze count +1. snooze with count == MAX_SNOOZE is ignored.
  - SNOOZE: on tick, decrement snooze counter; tick with counter==1 → RINGING, reloading ring counter = RING_TIMEOUT.
- Priority, highest first: armed low (forces IDLE from any state, clears counters) > stop (RINGING/SNOOZE → IDLE, snooze count cleared) > snooze > tick expiry.
- A snooze pulse in the same cycle as ring-timeout expiry goes to SNOOZE.
- trigger in RINGING or SNOOZE is ignored.
- Counter widths: $clog2(param+1). Arithmetic is unsigned.

## Timing
- All outputs are registered.
- ringing rises on the clk edge after the cycle in which match first becomes true, i.e. 1 cycle after the counters show HH:MM:00.
- Ringing lasts exactly RING_TIMEOUT tick pulses, counted from entry. A tick in the entry cycle is not counted.
- Snooze lasts exactly SNOOZE_TICKS tick pulses.
- stop, snooze and set_* take effect on the next clk edge.
- alarmMin/alarmHour update 1 cycle after the pulse.
- Asynchronous rst assertion mid-ring immediately clears all outputs. After release, the block resumes in IDLE. Because match_q is reset, if the time is still HH:MM:00 when rst releases, the alarm fires again.

## Configuration
- ALARM_BEEP_EN defined: buzz is 1 on entry to RINGING and toggles on every tick while RINGING, giving an intermittent beep. buzz is 0 in all other states.
- ALARM_BEEP_EN undefined: buzz equals ringing (steady tone). The toggle register is not built.

## Test plan
Benches use RING_TIMEOUT=4, SNOOZE_TICKS=3, MAX_SNOOZE=2.
- Setpoint wrap: updown=1, 60 set_min pulses from 0 → alarmMin back to 0 (passes through 59). updown=0, one set_hour from 0 → alarmHour=23.
- Basic alarm: alarm 07:30, armed=1, time advanced 07:29:59 → 07:30:00 → ringing=1 one cycle later. After 4 ticks, ringing=0 and state is IDLE.
- Snooze limit: ringing, snooze pulse → snoozing=1. After 3 ticks, ringing=1. Second snooze is accepted. Third snooze is ignored; ringing stays 1 until the 4-tick timeout.
- Priority: stop and snooze in the same cycle while ringing → IDLE (ringing=0, snoozing=0). armed dropped during SNOOZE → IDLE next edge, no re-ring.
- No false trigger: time held at 07:30:00, alarm set from 07:29 to 07:30 via set_min → ringing stays 0. Time counting down through 07:30:00 with alarm 07:30 → ringing=1.
- Beep/reset: with ALARM_BEEP_EN, buzz sequence over ringing ticks is 1,0,1,0. rst pulsed low mid-ring → all outputs 0 asynchronously, alarmMin/alarmHour=0.
